// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared defaults and FSM state encoding for the binary-to-BCD
//             converter (bin14_to_bcd4) and its digit correction cell.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Default geometry: 14-bit binary in, four BCD digits out, saturate at 9999
    localparam int c_BIN_W   = 14;
    localparam int c_DIGITS  = 4;
    localparam int c_MAX_VAL = 9999;

    // Converter FSM state encoding
    localparam int                c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_SHIFT = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adj
//  Purpose  : Double-dabble correction for one BCD digit: adds 3 when the
//             digit is 5 or more so the following left shift carries
//             correctly into the next decade.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Pure combinational add-3 correction
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin14_to_bcd4.sv
`default_nettype none
// ============================================================================
//  Module   : bin14_to_bcd4
//  Purpose  : Sequential double-dabble binary-to-BCD converter. One bit is
//             shifted per clock; the result is registered on entry to the
//             DONE state together with a saturation flag.
//             Optional feature macro: BCD_LEADING_BLANK_EN adds a registered
//             leading-zero blanking mask output (blank).
//  Revision : 1.0 - initial release
// ============================================================================
module bin14_to_bcd4
    import bcd_pkg::*;
#(
    parameter int BIN_W   = c_BIN_W,
    parameter int DIGITS  = c_DIGITS,
    parameter int MAX_VAL = c_MAX_VAL
)(
    input  logic                bcd_clk_signal,
    input  logic                reset_signal,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow
`ifdef BCD_LEADING_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    // Scratch carries one extra digit so full-range inputs never wrap
    localparam int              c_SW         = 4 * (DIGITS + 1);
    localparam int              c_CW         = $clog2(BIN_W + 1);
    localparam logic [c_CW-1:0] c_LAST_SHIFT = c_CW'(BIN_W - 1);

    logic [c_ST_W-1:0]   r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [c_SW-1:0]     r_scratch;
    logic [c_CW-1:0]     r_cnt;
    logic                r_sat;

    logic [c_SW-1:0]     w_adj;
    logic [c_SW-1:0]     w_next_scratch;
    logic                w_sat;
    logic [4*DIGITS-1:0] w_result;

    // One add-3 cell per scratch digit, including the guard digit
    for (genvar d = 0; d <= DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*d +: 4]),
            .o_digit (w_adj[4*d +: 4])
        );
    end

    // Next scratch after correction and one left shift of {scratch, bin}
    assign w_next_scratch = {w_adj[c_SW-2:0], r_bin[BIN_W-1]};

    // Saturate on an over-limit capture, or if the value no longer fits the
    // visible digits (only reachable with a MAX_VAL wider than DIGITS allows)
    assign w_sat = r_sat | w_adj[c_SW-1] | (|w_next_scratch[c_SW-1:4*DIGITS]);

    assign w_result = w_sat ? {DIGITS{4'h9}} : w_next_scratch[4*DIGITS-1:0];

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic              w_run_zero;

    // Leading-zero mask: a digit blanks only if it and every higher digit
    // are zero; the ones digit always stays visible
    always_comb begin
        w_blank    = '0;
        w_run_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_run_zero = w_run_zero & (w_result[4*d +: 4] == 4'h0);
            w_blank[d] = w_run_zero;
        end
    end
`endif

    // Control FSM, shift datapath and registered result outputs
    always_ff @(posedge bcd_clk_signal or posedge reset_signal) begin
        if (reset_signal) begin
            r_state   <= c_ST_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_sat     <= (32'(bin_in) > MAX_VAL);
                        busy      <= 1'b1;
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST_SHIFT) begin
                        done     <= 1'b1;
                        bcd_out  <= w_result;
                        overflow <= w_sat;
`ifdef BCD_LEADING_BLANK_EN
                        blank    <= w_blank;
`endif
                        r_state  <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin14_to_bcd4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin14_to_bcd4
//  Purpose  : Scoreboard bench for bin14_to_bcd4. Stimulus pushes expected
//             results (value, flag, mask, done cycle) into a queue; a monitor
//             pops and compares on every done pulse.
//             Optional feature macro: BCD_LEADING_BLANK_EN (checks blank).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin14_to_bcd4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blk;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [13:0] bin_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
`ifdef BCD_LEADING_BLANK_EN
    logic [3:0]  blank;
`endif

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    bin14_to_bcd4 #(
        .BIN_W   (14),
        .DIGITS  (4),
        .MAX_VAL (9999)
    ) dut (
        .bcd_clk_signal (clk),
        .reset_signal   (rst),
        .bin_in         (bin_in),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .bcd_out        (bcd_out),
        .overflow       (overflow)
`ifdef BCD_LEADING_BLANK_EN
        ,
        .blank          (blank)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency checking
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference conversion by decimal arithmetic (saturating)
    function automatic logic [15:0] ref_bcd(input int v);
        int t;
        t = (v > 9999) ? 9999 : v;
        ref_bcd = {4'((t / 1000) % 10), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    function automatic logic [3:0] ref_blank(input logic [15:0] b);
        logic [3:0] m;
        m[3] = (b[15:12] == 4'h0);
        m[2] = m[3] & (b[11:8] == 4'h0);
        m[1] = m[2] & (b[7:4] == 4'h0);
        m[0] = 1'b0;
        ref_blank = m;
    endfunction

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with no conversion pending (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                check("bcd_out", bcd_out, mon_e.bcd);
                check("overflow", overflow, mon_e.ovf);
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_in_done", busy, 1'b1);
`ifdef BCD_LEADING_BLANK_EN
                check("blank", blank, mon_e.blk);
`endif
            end
        end
    end

    // Sample the accept edge (start already driven) and queue its expectation
    task automatic accept(input logic [15:0] b, input logic o, input logic [3:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        e.bcd = b;
        e.ovf = o;
        e.blk = m;
        e.cyc = cyc + 14;
        q.push_back(e);
        check("busy_after_start", busy, 1'b1);
    endtask

    // Wait for the scoreboard to empty and the DUT to go idle, bounded
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending, busy=%0b, expected none", q.size(), busy);
            q.delete();
        end
    endtask

    task automatic convert(input logic [13:0] v, input logic [15:0] b, input logic o, input logic [3:0] m);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        accept(b, o, m);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    // Directed vectors with hand-computed results
    localparam int N_DIR = 8;
    logic [13:0] dir_in  [N_DIR] = '{14'd1234, 14'd9999, 14'd10000, 14'd42,
                                     14'd16383, 14'd1, 14'd8191, 14'd305};
    logic [15:0] dir_bcd [N_DIR] = '{16'h1234, 16'h9999, 16'h9999, 16'h0042,
                                     16'h9999, 16'h0001, 16'h8191, 16'h0305};
    logic        dir_ovf [N_DIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  dir_blk [N_DIR] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100,
                                     4'b0000, 4'b1110, 4'b0000, 4'b1000};

    // Main stimulus sequence
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd_out", bcd_out, 16'h0000);
        check("rst_overflow", overflow, 1'b0);

        // Start asserted with the release: honoured on the very next edge
        @(negedge clk);
        rst    = 1'b0;
        start  = 1'b1;
        bin_in = 14'd0;
        accept(16'h0000, 1'b0, 4'b1110);
        @(negedge clk);
        start = 1'b0;
        drain();

        for (int i = 0; i < N_DIR; i++) begin
            convert(dir_in[i], dir_bcd[i], dir_ovf[i], dir_blk[i]);
        end

        // Start held high with an incrementing input: accepts every 16 edges
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd100;
        for (int n = 0; n < 48; n++) begin
            @(posedge clk);
            #1;
            if (n % 16 == 0) begin
                exp_t e;
                e.bcd = ref_bcd(100 + n);
                e.ovf = 1'b0;
                e.blk = ref_blank(e.bcd);
                e.cyc = cyc + 14;
                q.push_back(e);
            end
            check("stream_busy", busy, (n % 16 != 15));
            @(negedge clk);
            bin_in = bin_in + 14'd1;
        end
        start = 1'b0;
        drain();

        // Reset during the seventh SHIFT cycle aborts the conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bcd_out", bcd_out, 16'h0000);
        check("abort_overflow", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        convert(14'd5678, 16'h5678, 1'b0, 4'b0000);

        // Input changes after capture must not disturb the result in flight
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd1234;
        accept(16'h1234, 1'b0, 4'b0000);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'd5678;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("hold_prior", bcd_out, 16'h5678);
        end
        drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
